// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output port.
// A three-state FSM drives the 2:1 mux select, limits bursts to MAX_BURST
// while the other source waits, and loads a single-entry output register.

// Scalable 2:1 mux, one bit slice per generate iteration.
module mux2 #(
    parameter int MUX_SIZE = 32
) (
    input  logic                sel_i,
    input  logic [MUX_SIZE-1:0] a_i,
    input  logic [MUX_SIZE-1:0] b_i,
    output logic [MUX_SIZE-1:0] y_o
);
    genvar gi;
    generate
        for (gi = 0; gi < MUX_SIZE; gi++) begin : g_bit
            assign y_o[gi] = sel_i ? b_i[gi] : a_i[gi];
        end
    endgenerate
endmodule

module mux_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    output logic                  gnt_a_o,
    input  logic                  req_b_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    output logic                  gnt_b_o,
    output logic                  sel_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    output logic                  out_src_o,
    input  logic                  out_ready_i,
    output logic                  busy_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    // Counter is 4 bits wide (MAX_BURST <= 15); the increment is done in 5 bits.
    localparam logic [4:0] MAX_W = 5'(MAX_BURST);
    localparam logic [3:0] MAX_C = 4'(MAX_BURST);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  sel_q, sel_d;
    logic                  last_q;          // 0 = A, 1 = B
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_src_q;

    logic                  slot;
    logic                  gnt_a, gnt_b;
    logic                  xfer_a, xfer_b;
    logic [4:0]            cnt_inc;
    logic                  burst_hit;
    logic [3:0]            cnt_sat;
    logic [DATA_WIDTH-1:0] mux_y;

    mux2 #(.MUX_SIZE(DATA_WIDTH)) u_mux (
        .sel_i (sel_q),
        .a_i   (data_a_i),
        .b_i   (data_b_i),
        .y_o   (mux_y)
    );

    // Grants depend only on registered state and the consumer's ready.
    always_comb begin
        slot      = !out_valid_q || out_ready_i;
        gnt_a     = (state_q == GRANT_A) && slot;
        gnt_b     = (state_q == GRANT_B) && slot;
        xfer_a    = req_a_i && gnt_a;
        xfer_b    = req_b_i && gnt_b;
        cnt_inc   = {1'b0, cnt_q} + 5'd1;
        burst_hit = (cnt_inc >= MAX_W);
        cnt_sat   = burst_hit ? MAX_C : cnt_inc[3:0];
    end

    // Next-state, burst counter and mux select.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (req_a_i && req_b_i) begin
                    state_d = last_q ? GRANT_A : GRANT_B;
                end else if (req_a_i) begin
                    state_d = GRANT_A;
                end else if (req_b_i) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (xfer_a) begin
                    if (req_b_i && burst_hit) begin
                        state_d = GRANT_B;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end else if (!req_a_i) begin
                    state_d = req_b_i ? GRANT_B : IDLE;
                    cnt_d   = 4'd0;
                end
            end
            GRANT_B: begin
                if (xfer_b) begin
                    if (req_a_i && burst_hit) begin
                        state_d = GRANT_A;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end else if (!req_b_i) begin
                    state_d = req_a_i ? GRANT_A : IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // Select follows the state being entered; IDLE keeps the old value.
        sel_d = sel_q;
        if (state_d == GRANT_B) begin
            sel_d = 1'b1;
        end else if (state_d == GRANT_A) begin
            sel_d = 1'b0;
        end
    end

    // FSM, counter and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Output register: load on a transfer, drain when consumed without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            last_q      <= 1'b1;
        end else if (xfer_a || xfer_b) begin
            out_data_q  <= mux_y;
            out_valid_q <= 1'b1;
            out_src_q   <= xfer_b;
            last_q      <= xfer_b;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign gnt_a_o     = gnt_a;
    assign gnt_b_o     = gnt_b;
    assign sel_o       = sel_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_src_o   = out_src_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: one instance with MAX_BURST = 4 and one
// with MAX_BURST = 1 share the same stimulus.
module tb_mux_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, req_b, out_ready;
    logic [31:0] data_a, data_b;

    logic        gnt_a, gnt_b, sel, out_valid, out_src, busy;
    logic [31:0] out_data;
    logic        g1_gnt_a, g1_gnt_b, g1_sel, g1_valid, g1_src, g1_busy;
    logic [31:0] g1_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a_i(req_a), .data_a_i(data_a), .gnt_a_o(gnt_a),
        .req_b_i(req_b), .data_b_i(data_b), .gnt_b_o(gnt_b),
        .sel_o(sel), .out_data_o(out_data), .out_valid_o(out_valid),
        .out_src_o(out_src), .out_ready_i(out_ready), .busy_o(busy)
    );

    mux_arbiter #(.DATA_WIDTH(32), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a_i(req_a), .data_a_i(data_a), .gnt_a_o(g1_gnt_a),
        .req_b_i(req_b), .data_b_i(data_b), .gnt_b_o(g1_gnt_b),
        .sel_o(g1_sel), .out_data_o(g1_data), .out_valid_o(g1_valid),
        .out_src_o(g1_src), .out_ready_i(out_ready), .busy_o(g1_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic exp_src4 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic exp_sel4 [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
        data_a = 32'h0; data_b = 32'h0;
        tick; tick;
        $display("reset: valid=%0b sel=%0b busy=%0b", out_valid, sel, busy);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sel",   {31'd0, sel},       32'd0);
        chk("rst_data",  out_data,           32'd0);
        chk("rst_gnt",   {30'd0, gnt_a, gnt_b}, 32'd0);
        rst_n = 1'b1;
        tick;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single source A.
        req_a = 1'b1; data_a = 32'h11;
        tick;
        $display("single: gnt_a=%0b busy=%0b", gnt_a, busy);
        chk("single_gnt_a", {31'd0, gnt_a}, 32'd1);
        chk("single_busy",  {31'd0, busy},  32'd1);
        chk("single_nv",    {31'd0, out_valid}, 32'd0);
        tick;
        $display("single: data=%0h valid=%0b src=%0b", out_data, out_valid, out_src);
        chk("single_data",  out_data, 32'h11);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_src",   {31'd0, out_src},   32'd0);
        req_a = 1'b0;
        tick;
        chk("single_drain", {31'd0, out_valid}, 32'd0);
        chk("single_idle",  {31'd0, busy},      32'd0);

        // Source B word in flight, then asynchronous reset.
        req_b = 1'b1; data_b = 32'h22;
        tick;
        chk("b_sel",   {31'd0, sel},   32'd1);
        chk("b_gnt_b", {31'd0, gnt_b}, 32'd1);
        tick;
        $display("b: data=%0h valid=%0b src=%0b", out_data, out_valid, out_src);
        chk("b_data",  out_data, 32'h22);
        chk("b_src",   {31'd0, out_src}, 32'd1);
        rst_n = 1'b0;
        #1;
        $display("midreset: valid=%0b sel=%0b gnt=%0b%0b", out_valid, sel, gnt_a, gnt_b);
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_sel",   {31'd0, sel},       32'd0);
        chk("mrst_gnt",   {30'd0, gnt_a, gnt_b}, 32'd0);
        chk("mrst_data",  out_data, 32'd0);
        req_b = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        chk("mrst_busy", {31'd0, busy}, 32'd0);

        // Both request right after reset: A first, groups of MAX_BURST.
        data_a = 32'hAA; data_b = 32'hBB; req_a = 1'b1; req_b = 1'b1;
        tick;
        chk("tie_gnt_a",  {31'd0, gnt_a},    32'd1);
        chk("tie_gnt_b",  {31'd0, gnt_b},    32'd0);
        chk("tie1_gnt_a", {31'd0, g1_gnt_a}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            tick;
            $display("burst k=%0d src4=%0b sel4=%0b data4=%0h src1=%0b sel1=%0b",
                     k, out_src, sel, out_data, g1_src, g1_sel);
            chk($sformatf("burst4_src%0d", k), {31'd0, out_src}, {31'd0, exp_src4[k]});
            chk($sformatf("burst4_sel%0d", k), {31'd0, sel},     {31'd0, exp_sel4[k]});
            chk($sformatf("burst4_val%0d", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("burst4_dat%0d", k), out_data, exp_src4[k] ? 32'hBB : 32'hAA);
            chk($sformatf("burst1_src%0d", k), {31'd0, g1_src},   {31'd0, k[0]});
            chk($sformatf("burst1_sel%0d", k), {31'd0, g1_sel},   {31'd0, ~k[0]});
            chk($sformatf("burst1_val%0d", k), {31'd0, g1_valid}, 32'd1);
        end

        // Backpressure: dut is in GRANT_A holding 0xAA.
        data_a = 32'hA1; out_ready = 1'b0;
        #1;
        chk("bp_gnt_now", {30'd0, gnt_a, gnt_b}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick;
            $display("stall k=%0d gnt=%0b%0b data=%0h", k, gnt_a, gnt_b, out_data);
            chk($sformatf("bp_gnt%0d", k),  {30'd0, gnt_a, gnt_b}, 32'd0);
            chk($sformatf("bp_data%0d", k), out_data, 32'hAA);
            chk($sformatf("bp_src%0d", k),  {31'd0, out_src}, 32'd0);
            chk($sformatf("bp_val%0d", k),  {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_gnt", {31'd0, gnt_a}, 32'd1);
        tick;
        $display("resume: data=%0h src=%0b", out_data, out_src);
        chk("bp_resume_data", out_data, 32'hA1);
        chk("bp_resume_src",  {31'd0, out_src}, 32'd0);

        // Withdrawal: A drops while B requests -> one bubble, fresh burst for B.
        req_a = 1'b0; data_b = 32'hB1;
        tick;
        $display("withdraw: valid=%0b sel=%0b gnt=%0b%0b", out_valid, sel, gnt_a, gnt_b);
        chk("wd_bubble", {31'd0, out_valid}, 32'd0);
        chk("wd_sel",    {31'd0, sel},       32'd1);
        chk("wd_gnt",    {30'd0, gnt_a, gnt_b}, 32'd1);
        tick;
        chk("wd_b0_data", out_data, 32'hB1);
        chk("wd_b0_src",  {31'd0, out_src}, 32'd1);
        req_a = 1'b1; data_a = 32'hA2;
        tick;
        chk("wd_b1_src", {31'd0, out_src}, 32'd1);
        tick;
        chk("wd_b2_src", {31'd0, out_src}, 32'd1);
        tick;
        chk("wd_b3_src", {31'd0, out_src}, 32'd1);
        chk("wd_b3_sel", {31'd0, sel},     32'd0);
        tick;
        $display("after burst: data=%0h src=%0b", out_data, out_src);
        chk("wd_a_src",  {31'd0, out_src}, 32'd0);
        chk("wd_a_data", out_data, 32'hA2);
        req_a = 1'b0;
        tick;
        chk("wd2_bubble", {31'd0, out_valid}, 32'd0);
        chk("wd2_sel",    {31'd0, sel},       32'd1);
        req_b = 1'b0;
        tick;
        $display("idle: busy=%0b sel=%0b valid=%0b", busy, sel, out_valid);
        chk("end_busy",  {31'd0, busy},      32'd0);
        chk("end_sel",   {31'd0, sel},       32'd1);
        chk("end_valid", {31'd0, out_valid}, 32'd0);
        chk("end_gnt",   {30'd0, gnt_a, gnt_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
